// File: rtl/clock_period_meter.sv
// Measures period and high time of an asynchronous signal in clock_in cycles.
// Single-shot or continuous, with a cycle-count timeout while waiting for edges.
module clock_period_meter #(
    parameter logic [27:0] TIMEOUT    = 28'd50_000_000,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        sig_in,
    input  logic        start,
    output logic        busy,
    output logic [27:0] period,
    output logic [27:0] high_time,
    output logic        valid,
    output logic        timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q, hist_q;
    logic [1:0]  warm_q;
    logic        edges_ok;
    logic        rise;
    logic        fall;
    logic [27:0] cnt_q;
    logic [27:0] hi_cap_q;
    logic        fell_q;
    logic        at_limit;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            warm_q  <= 2'd0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    // Edges stay masked until the chain holds real samples, so a level that
    // was already high at reset release is not mistaken for a rise.
    assign edges_ok = (warm_q == 2'd3);
    assign rise     = edges_ok & sync2_q & ~hist_q;
    assign fall     = edges_ok & ~sync2_q & hist_q;
    assign at_limit = (cnt_q == TIMEOUT - 28'd1);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StArm;
            end
            StArm: begin
                if (rise) begin
                    state_d = StMeasure;
                end else if (at_limit) begin
                    state_d = StIdle;
                end
            end
            StMeasure: begin
                if (rise) begin
                    state_d = CONTINUOUS ? StMeasure : StIdle;
                end else if (at_limit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

    // A rise always wins over the timeout limit in the same cycle.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 28'd0;
            hi_cap_q  <= 28'd0;
            fell_q    <= 1'b0;
            period    <= 28'd0;
            high_time <= 28'd0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) cnt_q <= 28'd0;
                end
                StArm: begin
                    if (rise) begin
                        cnt_q  <= 28'd1;
                        fell_q <= 1'b0;
                    end else if (at_limit) begin
                        timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 28'd1;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        period    <= cnt_q;
                        high_time <= fell_q ? hi_cap_q : 28'd0;
                        valid     <= 1'b1;
                        cnt_q     <= 28'd1;
                        fell_q    <= 1'b0;
                    end else if (at_limit) begin
                        timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 28'd1;
                        if (fall && !fell_q) begin
                            hi_cap_q <= cnt_q;
                            fell_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_q <= 28'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: single-shot and continuous instances checked each
// cycle against a timestamp-based model, plus directed literal expectations.
module tb_clock_period_meter;

    localparam int TO = 100;

    logic        clock_in = 1'b0;
    logic        reset_n;
    logic        sig_in;
    logic        start;

    logic        busy0, valid0, timeout0, busy1, valid1, timeout1;
    logic [27:0] period0, high0, period1, high1;

    clock_period_meter #(.TIMEOUT(28'd100), .CONTINUOUS(1'b0)) dut0 (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .sig_in   (sig_in),
        .start    (start),
        .busy     (busy0),
        .period   (period0),
        .high_time(high0),
        .valid    (valid0),
        .timeout  (timeout0)
    );

    clock_period_meter #(.TIMEOUT(28'd100), .CONTINUOUS(1'b1)) dut1 (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .sig_in   (sig_in),
        .start    (start),
        .busy     (busy1),
        .period   (period1),
        .high_time(high1),
        .valid    (valid1),
        .timeout  (timeout1)
    );

    always #5 clock_in = ~clock_in;

    logic        busy_a [2];
    logic        vld_a  [2];
    logic        to_a   [2];
    logic [27:0] per_a  [2];
    logic [27:0] hi_a   [2];
    assign busy_a[0] = busy0;    assign busy_a[1] = busy1;
    assign vld_a[0]  = valid0;   assign vld_a[1]  = valid1;
    assign to_a[0]   = timeout0; assign to_a[1]   = timeout1;
    assign per_a[0]  = period0;  assign per_a[1]  = period1;
    assign hi_a[0]   = high0;    assign hi_a[1]   = high1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", name, idx, $time, act, exp);
        end
    endtask

    // Model: timestamps in clock edges since reset release; 0 idle, 1 arm, 2 measure.
    typedef struct {
        int mode;
        int arm_k;
        int ref_k;
        int fall_k;
        int per;
        int hi;
        bit vld;
        bit to;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t n;
        n.mode = 0; n.arm_k = 0; n.ref_k = 0; n.fall_k = -1;
        n.per = 0; n.hi = 0; n.vld = 1'b0; n.to = 1'b0;
        return n;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit cont, input bit st, input bit r,
                                   input bit f, input int k);
        mdl_t n = m;
        n.vld = 1'b0;
        n.to  = 1'b0;
        case (n.mode)
            0: if (st) begin
                n.mode  = 1;
                n.arm_k = k;
            end
            1: if (r) begin
                n.mode   = 2;
                n.ref_k  = k;
                n.fall_k = -1;
            end else if (k - n.arm_k == TO) begin
                n.mode = 0;
                n.to   = 1'b1;
            end
            2: if (r) begin
                n.per = k - n.ref_k;
                n.hi  = (n.fall_k < 0) ? 0 : n.fall_k - n.ref_k;
                n.vld = 1'b1;
                if (cont) begin
                    n.ref_k  = k;
                    n.fall_k = -1;
                end else begin
                    n.mode = 0;
                end
            end else begin
                if (f && n.fall_k < 0) n.fall_k = k;
                if (k - n.ref_k == TO - 1) begin
                    n.mode = 0;
                    n.to   = 1'b1;
                end
            end
            default: n.mode = 0;
        endcase
        return n;
    endfunction

    mdl_t md [2];
    int   k;
    int   cyc = 0;
    bit   s1, s2, s3;

    // Observation bookkeeping for directed expectations.
    int vcount [2];
    int tcount [2];
    int last_v [2];
    int gap    [2];
    int to_cyc [2];
    int busy_cyc [2];
    bit prev_busy [2];

    always @(posedge clock_in) begin
        bit r, f;
        cyc++;
        if (!reset_n) begin
            k = 0; s1 = 0; s2 = 0; s3 = 0;
            md[0] = mreset();
            md[1] = mreset();
        end else begin
            k++;
            // Edges surface three samples late and only once the delay line is filled.
            r = (k >= 4) && s2 && !s3;
            f = (k >= 4) && !s2 && s3;
            md[0] = mstep(md[0], 1'b0, start, r, f, k);
            md[1] = mstep(md[1], 1'b1, start, r, f, k);
            s3 = s2; s2 = s1; s1 = sig_in;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("busy", i, {31'd0, busy_a[i]}, {31'd0, md[i].mode != 0});
            chk("valid", i, {31'd0, vld_a[i]}, {31'd0, md[i].vld});
            chk("timeout", i, {31'd0, to_a[i]}, {31'd0, md[i].to});
            chk("period", i, {4'd0, per_a[i]}, md[i].per);
            chk("high_time", i, {4'd0, hi_a[i]}, md[i].hi);
            chk("valid_and_timeout", i, {31'd0, vld_a[i] & to_a[i]}, 32'd0);
            if (vld_a[i] === 1'b1) begin
                vcount[i]++;
                if (last_v[i] >= 0) gap[i] = cyc - last_v[i];
                last_v[i] = cyc;
            end
            if (to_a[i] === 1'b1) begin
                tcount[i]++;
                to_cyc[i] = cyc;
            end
            if (busy_a[i] === 1'b1 && !prev_busy[i]) busy_cyc[i] = cyc;
            prev_busy[i] = (busy_a[i] === 1'b1);
        end
    end

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            vcount[i] = 0; tcount[i] = 0; last_v[i] = -1; gap[i] = 0;
            to_cyc[i] = 0; busy_cyc[i] = 0;
        end
    endtask

    // Stimulus: 0 hold level, 1 square wave 10/4, 2 random toggling.
    int mode = 0;
    bit level = 0;
    bit start_req = 0;
    int sq_ph = 0;
    int hold_left = 0;

    task automatic tick();
        @(negedge clock_in);
        case (mode)
            1: begin
                sig_in = (sq_ph < 4);
                sq_ph  = (sq_ph + 1) % 10;
            end
            2: begin
                if (hold_left == 0) begin
                    sig_in    = ~sig_in;
                    hold_left = ($urandom_range(0, 15) == 0) ? int'($urandom_range(90, 130))
                                                             : int'($urandom_range(0, 11));
                end else begin
                    hold_left--;
                end
            end
            default: sig_in = level;
        endcase
        start     = start_req;
        start_req = 1'b0;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic do_reset();
        @(negedge clock_in);
        #2;
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, {31'd0, busy_a[i]}, 32'd0);
            chk("rst_valid", i, {31'd0, vld_a[i]}, 32'd0);
            chk("rst_timeout", i, {31'd0, to_a[i]}, 32'd0);
            chk("rst_period", i, {4'd0, per_a[i]}, 32'd0);
            chk("rst_high", i, {4'd0, hi_a[i]}, 32'd0);
        end
        repeat (2) @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        sig_in  = 1'b0;
        start   = 1'b0;
        clear_obs();
        prev_busy[0] = 0; prev_busy[1] = 0;
        repeat (3) @(negedge clock_in);
        reset_n = 1'b1;

        // Wave in IDLE without start: nothing moves.
        mode = 1;
        run(30);
        for (int i = 0; i < 2; i++) begin
            chk("idle_no_valid", i, vcount[i], 0);
            chk("idle_busy", i, {31'd0, busy_a[i]}, 0);
        end

        // Single shot and continuous on a 10/4 wave.
        start_req = 1'b1;
        run(60);
        chk("single_count", 0, vcount[0], 1);
        chk("single_period", 0, {4'd0, period0}, 10);
        chk("single_high", 0, {4'd0, high0}, 4);
        chk("single_busy", 0, {31'd0, busy0}, 0);
        chk("cont_many", 1, {31'd0, vcount[1] >= 4}, 1);
        chk("cont_gap", 1, gap[1], 10);
        chk("cont_period", 1, {4'd0, period1}, 10);
        chk("cont_high", 1, {4'd0, high1}, 4);
        chk("cont_busy", 1, {31'd0, busy1}, 1);
        start_req = 1'b1;   // ignored by the busy continuous instance
        run(30);
        chk("cont_after_start_gap", 1, gap[1], 10);
        chk("cont_after_start_busy", 1, {31'd0, busy1}, 1);

        // Timeout from ARM with sig_in held low.
        do_reset();
        mode = 0; level = 0;
        run(5);
        clear_obs();
        start_req = 1'b1;
        run(110);
        for (int i = 0; i < 2; i++) begin
            chk("arm_to_delay", i, to_cyc[i] - busy_cyc[i], 100);
            chk("arm_to_count", i, tcount[i], 1);
            chk("arm_to_no_valid", i, vcount[i], 0);
            chk("arm_to_period", i, {4'd0, per_a[i]}, 0);
        end

        // Timeout from MEASURE keeps the previously latched results.
        do_reset();
        mode = 1;
        run(5);
        start_req = 1'b1;
        run(40);
        mode = 0; level = 0;
        run(120);
        clear_obs();
        start_req = 1'b1;
        run(5);
        level = 1;
        run(120);
        for (int i = 0; i < 2; i++) begin
            chk("meas_to_count", i, tcount[i], 1);
            chk("meas_to_no_valid", i, vcount[i], 0);
            chk("meas_to_period", i, {4'd0, per_a[i]}, 10);
            chk("meas_to_high", i, {4'd0, hi_a[i]}, 4);
            chk("meas_to_busy", i, {31'd0, busy_a[i]}, 0);
        end

        // Reset in the middle of a measurement, then a clean one.
        mode = 1;
        start_req = 1'b1;
        run(40);
        clear_obs();
        do_reset();
        run(5);
        chk("post_reset_no_valid", 0, vcount[0] + vcount[1], 0);
        start_req = 1'b1;
        run(40);
        chk("post_reset_count", 0, vcount[0], 1);
        chk("post_reset_period", 0, {4'd0, period0}, 10);
        chk("post_reset_high", 0, {4'd0, high0}, 4);

        // Level already high at reset release is not a rise.
        mode = 0; level = 1;
        run(3);
        do_reset();
        clear_obs();
        start_req = 1'b1;
        run(110);
        for (int i = 0; i < 2; i++) begin
            chk("high_at_release_to", i, tcount[i], 1);
            chk("high_at_release_no_valid", i, vcount[i], 0);
        end

        // Rise coinciding with the limit in ARM, then in MEASURE.
        level = 0;
        run(5);
        clear_obs();
        start_req = 1'b1;
        run(1);
        run(97);
        level = 1;
        run(1);
        run(3);
        for (int i = 0; i < 2; i++) begin
            chk("arm_limit_rise_no_to", i, tcount[i], 0);
            chk("arm_limit_rise_busy", i, {31'd0, busy_a[i]}, 1);
        end
        run(7);
        level = 0;
        run(88);
        level = 1;
        run(1);
        run(6);
        chk("meas_limit_count", 0, vcount[0], 1);
        chk("meas_limit_period", 0, {4'd0, period0}, 99);
        chk("meas_limit_high", 0, {4'd0, high0}, 11);
        chk("meas_limit_no_to", 0, tcount[0], 0);

        // Randomized traffic against the model.
        do_reset();
        mode = 2;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            if ($urandom_range(0, 15) == 0) start_req = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
